// File: rtl/seg7_value_if.sv
// Value handshake between a producer and the 7-segment scan controller.
// A transfer happens on any rising clk edge where value_valid && value_ready; the producer holds value_in stable while valid and not ready.
interface seg7_value_if;
    logic [7:0] value_in;
    logic       value_valid;
    logic       value_ready;

    modport master (output value_in, output value_valid, input value_ready);
    modport slave  (input value_in, input value_valid, output value_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller with frame-aligned value commit
// and a segment-dark gap at every digit switch.
module seg7_scan_ctrl #(
    parameter int CLK_HZ       = 12000000,
    parameter int REFRESH_HZ   = 100,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        lz_blank,
    seg7_value_if.slave val,
    output logic [3:0]  digit_addr,
    output logic        digit_sel,
    output logic        seg_on,
    output logic        frame_tick,
    output logic [7:0]  shown_value,
    output logic [2:0]  dbg_state
);
    localparam int DWELL    = CLK_HZ / (2 * REFRESH_HZ);
    localparam int SHOW_LEN = DWELL - BLANK_CYCLES;
    localparam int CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [2:0] {IDLE, SHOW_HI, BLANK_HL, SHOW_LO, BLANK_LH} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic [7:0]       shown_q, shown_d;
    logic [3:0]       digit_addr_q, digit_addr_d;
    logic             digit_sel_q, digit_sel_d;
    logic             seg_on_q, seg_on_d;
    logic             frame_tick_q, frame_tick_d;
    logic             commit, accept;

    // State register plus all registered outputs and the value datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            shown_q        <= '0;
            digit_addr_q   <= '0;
            digit_sel_q    <= 1'b1;
            seg_on_q       <= 1'b0;
            frame_tick_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            shown_q        <= shown_d;
            digit_addr_q   <= digit_addr_d;
            digit_sel_q    <= digit_sel_d;
            seg_on_q       <= seg_on_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW_HI;
                    cnt_d   = '0;
                end
                SHOW_HI: if (cnt_q == CNT_W'(SHOW_LEN - 1)) begin
                    state_d = BLANK_HL;
                    cnt_d   = '0;
                end
                BLANK_HL: if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = SHOW_LO;
                    cnt_d   = '0;
                end
                SHOW_LO: if (cnt_q == CNT_W'(SHOW_LEN - 1)) begin
                    state_d = BLANK_LH;
                    cnt_d   = '0;
                end
                BLANK_LH: if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = SHOW_HI;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Entering SHOW_HI from anywhere else is the frame boundary; only there may the shown value change.
    assign commit = (state_d == SHOW_HI) && (state_q != SHOW_HI);
    assign accept = val.value_valid && !pending_full_q;

    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        shown_d        = shown_q;
        if (commit && pending_full_q) begin
            shown_d        = pending_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = val.value_in;
            pending_full_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_comb begin
        digit_sel_d  = 1'b1;
        digit_addr_d = shown_d[7:4];
        seg_on_d     = 1'b0;
        frame_tick_d = commit;
        case (state_d)
            SHOW_HI:  seg_on_d = !(lz_blank && (shown_d[7:4] == 4'h0));
            BLANK_HL: begin
                digit_sel_d  = 1'b0;
                digit_addr_d = shown_d[3:0];
            end
            SHOW_LO: begin
                digit_sel_d  = 1'b0;
                digit_addr_d = shown_d[3:0];
                seg_on_d     = 1'b1;
            end
            default: ;
        endcase
    end

    assign val.value_ready = !pending_full_q;
    assign digit_addr      = digit_addr_q;
    assign digit_sel       = digit_sel_q;
    assign seg_on          = seg_on_q;
    assign frame_tick      = frame_tick_q;
    assign shown_value     = shown_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DWELL=10, BLANK_CYCLES=2 (20-cycle frame).
module tb_seg7_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       lz_blank;
  logic [3:0] digit_addr;
  logic       digit_sel;
  logic       seg_on;
  logic       frame_tick;
  logic [7:0] shown_value;
  logic [2:0] dbg_state;

  seg7_value_if vif ();

  seg7_scan_ctrl #(
    .CLK_HZ      (1000),
    .REFRESH_HZ  (50),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .val        (vif),
    .digit_addr (digit_addr),
    .digit_sel  (digit_sel),
    .seg_on     (seg_on),
    .frame_tick (frame_tick),
    .shown_value(shown_value),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1);
  end

  // expected per-cycle outputs of one frame
  typedef struct {
    logic       sel;
    logic [3:0] addr;
    logic       seg;
    logic       tick;
  } vec_t;

  vec_t       frame_tbl[20];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  function automatic void build_frame(input logic [7:0] v, input logic lz);
    for (int i = 0; i < 20; i++) begin
      frame_tbl[i].tick = (i == 0);
      if (i < 8) begin
        frame_tbl[i].sel  = 1'b1;
        frame_tbl[i].addr = v[7:4];
        frame_tbl[i].seg  = !(lz && v[7:4] == 4'h0);
      end else if (i < 10) begin
        frame_tbl[i].sel  = 1'b0;
        frame_tbl[i].addr = v[3:0];
        frame_tbl[i].seg  = 1'b0;
      end else if (i < 18) begin
        frame_tbl[i].sel  = 1'b0;
        frame_tbl[i].addr = v[3:0];
        frame_tbl[i].seg  = 1'b1;
      end else begin
        frame_tbl[i].sel  = 1'b1;
        frame_tbl[i].addr = v[7:4];
        frame_tbl[i].seg  = 1'b0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    vif.value_in    = v;
    vif.value_valid = 1'b1;
    while (!vif.value_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready_wait", 32'(n < 50), 1);
    tick();
    vif.value_valid = 1'b0;
    exp_q.push_back(v);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    while (!frame_tick && n < 50) begin
      tick();
      n++;
    end
    check("frame_tick_timeout", 32'(frame_tick), 1);
  endtask

  task automatic expect_commit();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("commit_queue_empty", 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      check("commit_value", 32'(shown_value), 32'(e));
    end
  endtask

  task automatic check_frame();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("frame_sel[%0d]", i), 32'(digit_sel), 32'(frame_tbl[i].sel));
      check($sformatf("frame_addr[%0d]", i), 32'(digit_addr), 32'(frame_tbl[i].addr));
      check($sformatf("frame_seg[%0d]", i), 32'(seg_on), 32'(frame_tbl[i].seg));
      check($sformatf("frame_tick[%0d]", i), 32'(frame_tick), 32'(frame_tbl[i].tick));
      tick();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, 32'(digit_addr), 0);
    check({tag, "_sel"}, 32'(digit_sel), 1);
    check({tag, "_seg"}, 32'(seg_on), 0);
    check({tag, "_tick"}, 32'(frame_tick), 0);
    check({tag, "_ready"}, 32'(vif.value_ready), 1);
    check({tag, "_shown"}, 32'(shown_value), 0);
  endtask

  initial begin
    int n;
    reset           = 1'b1;
    enable          = 1'b0;
    lz_blank        = 1'b0;
    vif.value_in    = 8'h00;
    vif.value_valid = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    check("idle_seg", 32'(seg_on), 0);

    // 1: accept while idle, commit on the first frame after enable
    vif.value_in    = 8'hA5;
    vif.value_valid = 1'b1;
    tick();
    vif.value_valid = 1'b0;
    exp_q.push_back(8'hA5);
    check("t1_ready_fall", 32'(vif.value_ready), 0);
    check("t1_shown_before", 32'(shown_value), 0);
    enable = 1'b1;
    tick();
    check("t1_first_tick", 32'(frame_tick), 1);
    expect_commit();
    check("t1_ready_back", 32'(vif.value_ready), 1);
    build_frame(8'hA5, 1'b0);
    check_frame();
    check_frame();

    // 2: mid-frame update waits for the frame boundary
    repeat (15) tick();
    send(8'h3C);
    n = 0;
    while (!frame_tick && n < 50) begin
      check("t2_shown_hold", 32'(shown_value), 32'h A5);
      check("t2_ready_low", 32'(vif.value_ready), 0);
      tick();
      n++;
    end
    check("t2_cycles_to_commit", 32'(n), 4);
    check("t2_tick", 32'(frame_tick), 1);
    expect_commit();
    check("t2_ready_high", 32'(vif.value_ready), 1);

    // 3: second value held off while pending is full
    send(8'h77);
    vif.value_in    = 8'h42;
    vif.value_valid = 1'b1;
    n = 0;
    while (!frame_tick && n < 50) begin
      check("t3_ready_low", 32'(vif.value_ready), 0);
      check("t3_shown_hold", 32'(shown_value), 32'h3C);
      tick();
      n++;
    end
    check("t3_cycles_to_commit", 32'(n), 19);
    expect_commit();
    check("t3_ready_high", 32'(vif.value_ready), 1);
    tick();
    vif.value_valid = 1'b0;
    exp_q.push_back(8'h42);
    check("t3_second_accept", 32'(vif.value_ready), 0);
    wait_frame(n);
    check("t3_frame_period", 32'(n), 19);
    expect_commit();

    // 4: leading-zero suppression
    lz_blank = 1'b1;
    send(8'h07);
    wait_frame(n);
    expect_commit();
    build_frame(8'h07, 1'b1);
    check_frame();
    send(8'h00);
    wait_frame(n);
    expect_commit();
    build_frame(8'h00, 1'b1);
    check_frame();

    // 5: enable dropped mid SHOW_HI, then restored
    lz_blank = 1'b0;
    repeat (3) tick();
    check("t5_pre_seg", 32'(seg_on), 1);
    enable = 1'b0;
    tick();
    check("t5_off_seg", 32'(seg_on), 0);
    check("t5_off_sel", 32'(digit_sel), 1);
    check("t5_off_tick", 32'(frame_tick), 0);
    tick();
    check("t5_idle_seg", 32'(seg_on), 0);
    enable = 1'b1;
    tick();
    build_frame(8'h00, 1'b0);
    check_frame();

    // 6: reset during BLANK_HL discards pending
    send(8'h99);
    check("t6_pending_full", 32'(vif.value_ready), 0);
    repeat (7) tick();
    check("t6_blank_sel", 32'(digit_sel), 0);
    check("t6_blank_seg", 32'(seg_on), 0);
    reset = 1'b1;
    tick();
    check_reset_values("t6_reset");
    exp_q.delete();
    reset = 1'b0;
    tick();
    check("t6_restart_tick", 32'(frame_tick), 1);
    check("t6_no_commit", 32'(shown_value), 0);
    check("t6_ready", 32'(vif.value_ready), 1);
    build_frame(8'h00, 1'b0);
    check_frame();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the two-digit common-pin 7-segment display on the Alhambra II.
- Accepts an 8-bit value through a valid/ready handshake and holds it in a pending register.
- Commits the pending value only at frame boundaries, so digits never tear.
- Alternates the digit-select pin at the refresh rate, feeds the per-digit nibble to the downstream hex segment decoder ROM, and inserts a blanking gap at every digit switch to prevent ghosting.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- REFRESH_HZ, 100, full two-digit frame rate in Hz.
- BLANK_CYCLES, 64, segment-off cycles at each digit switch; must be >= 1 and < DWELL.
- DWELL (derived localparam), CLK_HZ/(2*REFRESH_HZ), cycles per digit slot (show + blank).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- enable  in  1  scan enable; 0 forces idle with display dark
- lz_blank  in  1  1 = suppress leading zero (high nibble == 0)
- value_in  in  8  value to display
- value_valid  in  1  value_in is offered
- value_ready  out  1  pending register empty; transfer occurs when valid && ready
- digit_addr  out  4  nibble index to the hex segment decoder
- digit_sel  out  1  display control pin; 1 = first (high) digit, 0 = second (low) digit
- seg_on  out  1  segment drive enable; 0 = all segments off
- frame_tick  out  1  one-cycle pulse on the first cycle of each frame
- shown_value  out  8  value currently committed for display

Behaviour:
- All outputs are registered. Reset values: digit_addr=0, digit_sel=1, seg_on=0, frame_tick=0, value_ready=1, shown_value=0. The pending register is cleared and the FSM goes to IDLE.
- FSM states: IDLE, SHOW_HI, BLANK_HL, SHOW_LO, BLANK_LH. A slot counter runs 0..n-1 and restarts on every state change.
- IDLE:
  - Outputs: seg_on=0, digit_sel=1, digit_addr=shown_value[7:4].
  - enable=1 sampled in cycle n gives SHOW_HI visible in cycle n+1.
- SHOW_HI: lasts DWELL-BLANK_CYCLES cycles.
  - digit_sel=1, digit_addr=shown_value[7:4].
  - seg_on = !(lz_blank && shown_value[7:4]==0), with lz_blank evaluated live.
  - Next state: BLANK_HL.
- BLANK_HL: lasts BLANK_CYCLES cycles.
  - seg_on=0, digit_sel=0, digit_addr=shown_value[3:0].
  - Select and address switch here, while the segments are dark.
  - Next state: SHOW_LO.
- SHOW_LO: lasts DWELL-BLANK_CYCLES cycles.
  - seg_on=1, digit_sel=0, digit_addr=shown_value[3:0]. The low digit is never suppressed.
  - Next state: BLANK_LH.
- BLANK_LH: lasts BLANK_CYCLES cycles.
  - seg_on=0, digit_sel=1, digit_addr=shown_value[7:4].
  - Next state: SHOW_HI.
- Frame length: exactly 2*DWELL cycles.
- Frame boundary (transition into SHOW_HI from BLANK_LH or IDLE):
  - If pending is full: shown_value <= pending, pending cleared, value_ready returns to 1 the next cycle.
  - The first SHOW_HI cycle already shows the new value's high nibble.
  - frame_tick=1 for that first cycle only.
- Handshake:
  - value_ready = !pending_full.
  - Accepting a value sets pending_full and drops value_ready the next cycle.
  - value_valid while ready=0 is ignored; the producer holds.
  - With no pending value, shown_value persists across frames.
- Deasserting enable mid-frame: IDLE on the next cycle, seg_on=0 at once, slot counter cleared. Pending is retained and the handshake keeps working in IDLE. Re-enabling restarts at SHOW_HI and commits pending.
- Reset mid-frame: outputs take their reset values on the next cycle and pending is discarded.
- Counter width: $clog2(DWELL). No wrap beyond DWELL-1.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=1000, REFRESH_HZ=50, which gives DWELL=10. BLANK_CYCLES=2.
1. Reset, enable=1, send 0xA5 -> value_ready falls 1 cycle after accept. Commit at next SHOW_HI with frame_tick=1. Sequence per frame: 8 cycles sel=1/addr=A/seg_on=1, 2 cycles sel=0/addr=5/seg_on=0, 8 cycles sel=0/addr=5/seg_on=1, 2 cycles sel=1/addr=A/seg_on=0. frame_tick period = 20 cycles.
2. Mid-frame at cycle 5 of SHOW_LO, send 0x3C -> shown_value stays 0xA5 until the next frame_tick, then becomes 0x3C. value_ready is 0 from accept to commit.
3. Pending full, producer holds valid with 0x77 and a second value waiting -> second value not taken while ready=0. 0x77 is displayed on the next frame; the second value is accepted the cycle after ready rises.
4. lz_blank=1, value 0x07 -> seg_on=0 through SHOW_HI and =1 through SHOW_LO. With lz_blank=1 and value 0x00, the low digit still shows '0'.
5. enable dropped at SHOW_HI cycle 3 -> seg_on=0 next cycle, sel=1. Re-enable -> SHOW_HI with frame_tick on the following cycle and a full 8-cycle show.
6. reset asserted during BLANK_HL with pending full -> next cycle all reset values, value_ready=1, shown_value=0, pending lost (no commit after re-enable).
